// File: rtl/mips_pkg.sv
// mips_pkg: types and constants shared by the MIPS pipeline stages.
package mips_pkg;
  localparam int WORD_BYTES = 4;
  localparam int XLEN = 32;
  typedef enum logic {RUN, HALT} fetch_state_e;
  typedef struct packed {
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;
endpackage

// File: rtl/pc_register.sv
// pc_register: program counter with load enable and the redirect / sequential next-PC mux.
module pc_register import mips_pkg::*; #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load_en,
  input  logic                  i_redirect,
  input  logic [DATA_WIDTH-1:0] i_redirect_pc,
  output logic [DATA_WIDTH-1:0] o_pc
);
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  always_comb pc_d = i_redirect ? i_redirect_pc : pc_q + DATA_WIDTH'(WORD_BYTES);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) pc_q <= RESET_PC;
    else if (i_load_en) pc_q <= pc_d;
  assign o_pc = pc_q;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: MIPS fetch stage; owns the PC, reads the ROM and fills the IF/ID register.
module instruction_fetch import mips_pkg::*; #(
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic                  i_redirect,
  input  logic [DATA_WIDTH-1:0] i_redirect_pc,
  input  logic [DATA_WIDTH-1:0] i_instruction,
  output logic [DATA_WIDTH-1:0] o_address,
  output logic [DATA_WIDTH-1:0] o_if_id_instruction,
  output logic [DATA_WIDTH-1:0] o_if_id_pc_plus4,
  output logic                  o_if_id_valid,
  output logic                  o_halted,
  output logic [31:0]           o_fetch_count
);
  localparam logic [DATA_WIDTH:0] PC_LIMIT = (DATA_WIDTH+1)'(MEMORY_DEPTH * WORD_BYTES);
  fetch_state_e          state_q;
  if_id_t                if_id_q, if_id_d;
  logic [31:0]           count_q;
  logic [DATA_WIDTH-1:0] pc, pc_plus4;
  logic                  illegal, run, squash, capture;
  assign illegal  = pc[1:0] != 2'b00 || {1'b0, pc} >= PC_LIMIT;
  assign run      = state_q == RUN;
  assign squash   = illegal || i_flush || i_redirect;
  assign capture  = run && !squash && !i_stall;
  assign pc_plus4 = pc + DATA_WIDTH'(WORD_BYTES);
  pc_register #(.DATA_WIDTH(DATA_WIDTH), .RESET_PC(RESET_PC)) u_pc (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_load_en    (run && !illegal && !i_stall),
    .i_redirect   (i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .o_pc         (pc)
  );
  // Squash wins over stall, so flush+stall empties IF/ID while the PC holds.
  always_comb if_id_d = squash ? '0 : i_stall ? if_id_q
                      : '{instruction: i_instruction, pc_plus4: pc_plus4, valid: 1'b1};
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= RUN;
      if_id_q <= '0;
      count_q <= '0;
    end else if (run) begin
      state_q <= illegal ? HALT : RUN;
      if_id_q <= if_id_d;
      count_q <= count_q + 32'(capture);
    end
  assign o_address           = pc;
  assign o_if_id_instruction = if_id_q.instruction;
  assign o_if_id_pc_plus4    = if_id_q.pc_plus4;
  assign o_if_id_valid       = if_id_q.valid;
  assign o_halted            = state_q == HALT;
  assign o_fetch_count       = count_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed and randomized checks of the fetch stage against a behavioural model.
module tb_instruction_fetch;
  localparam int DEPTH = 32;
  logic        i_clk = 0, i_rst_n = 1, i_stall = 0, i_flush = 0, i_redirect = 0;
  logic [31:0] i_redirect_pc = 0, i_instruction;
  logic [31:0] o_address, o_ins, o_pp4, o_fetch_count;
  logic        o_valid, o_halted;
  logic [31:0] rom [DEPTH];
  logic [31:0] m_pc, m_ins, m_pp4, m_cnt;
  logic        m_valid, m_halt;
  logic        run_cmp = 0;
  int          checks = 0, failures = 0;

  instruction_fetch #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_stall            (i_stall),
    .i_flush            (i_flush),
    .i_redirect         (i_redirect),
    .i_redirect_pc      (i_redirect_pc),
    .i_instruction      (i_instruction),
    .o_address          (o_address),
    .o_if_id_instruction(o_ins),
    .o_if_id_pc_plus4   (o_pp4),
    .o_if_id_valid      (o_valid),
    .o_halted           (o_halted),
    .o_fetch_count      (o_fetch_count)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a[1:0] == 2'b00 && a < DEPTH * 4) ? rom[a[$clog2(DEPTH)+1:2]] : 32'hDEAD_BEEF;
  endfunction

  always_comb i_instruction = rom_word(o_address);

  // Reference: what IF/ID and the PC must hold after each edge.
  always @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      m_pc <= 0; m_ins <= 0; m_pp4 <= 0; m_valid <= 0; m_halt <= 0; m_cnt <= 0;
    end else if (!m_halt) begin
      if (m_pc % 4 != 0 || m_pc >= DEPTH * 4) begin
        m_halt <= 1; m_valid <= 0; m_ins <= 0; m_pp4 <= 0;
      end else begin
        if (i_flush || i_redirect) begin
          m_ins <= 0; m_pp4 <= 0; m_valid <= 0;
        end else if (!i_stall) begin
          m_ins <= rom_word(m_pc); m_pp4 <= m_pc + 4; m_valid <= 1; m_cnt <= m_cnt + 1;
        end
        if (!i_stall) m_pc <= i_redirect ? i_redirect_pc : m_pc + 4;
      end
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic cmp_model();
    chk("address", o_address, m_pc);
    chk("instruction", o_ins, m_ins);
    chk("pc_plus4", o_pp4, m_pp4);
    chk("valid", 32'(o_valid), 32'(m_valid));
    chk("halted", 32'(o_halted), 32'(m_halt));
    chk("fetch_count", o_fetch_count, m_cnt);
  endtask

  always @(negedge i_clk) if (run_cmp) cmp_model();

  task automatic cyc(input logic st, input logic fl, input logic rd, input logic [31:0] rpc);
    i_stall = st; i_flush = fl; i_redirect = rd; i_redirect_pc = rpc;
    @(posedge i_clk); #1;
  endtask

  // Reset lands mid-cycle; outputs must clear before any clock edge.
  task automatic async_reset();
    @(posedge i_clk); #3;
    i_rst_n = 0; #1;
    chk("rst_address", o_address, 0);
    chk("rst_instruction", o_ins, 0);
    chk("rst_pc_plus4", o_pp4, 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_halted", 32'(o_halted), 0);
    chk("rst_count", o_fetch_count, 0);
    i_stall = 0; i_flush = 0; i_redirect = 0;
    @(negedge i_clk); i_rst_n = 1; #1;
  endtask

  initial begin
    logic [31:0] tgt;
    int r;
    for (int k = 0; k < DEPTH; k++) rom[k] = 32'h1000_0000 + k;
    #1 i_rst_n = 0;
    run_cmp = 1;
    async_reset();
    chk("start_address", o_address, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 0);
      chk("free_address", o_address, 32'(4 * (k + 1)));
      chk("free_instruction", o_ins, 32'h1000_0000 + 32'(k));
    end
    chk("free_pc_plus4", o_pp4, 20);
    chk("free_count", o_fetch_count, 5);

    async_reset();
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0);
    chk("stall_address", o_address, 8);
    chk("stall_instruction", o_ins, 32'h1000_0001);
    chk("stall_valid", 32'(o_valid), 1);
    chk("stall_count", o_fetch_count, 2);
    cyc(0, 0, 0, 0);
    chk("resume_instruction", o_ins, 32'h1000_0002);
    chk("resume_address", o_address, 12);
    chk("resume_count", o_fetch_count, 3);
    cyc(0, 0, 1, 32'h40);
    chk("redirect_address", o_address, 32'h40);
    chk("redirect_bubble", 32'(o_valid), 0);
    cyc(0, 0, 0, 0);
    chk("redirect_instruction", o_ins, 32'h1000_0010);
    chk("redirect_pc_plus4", o_pp4, 32'h44);
    chk("redirect_valid", 32'(o_valid), 1);

    async_reset();
    repeat (5) cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    chk("flush_stall_valid", 32'(o_valid), 0);
    chk("flush_stall_address", o_address, 20);
    cyc(0, 1, 0, 0);
    chk("flush_valid", 32'(o_valid), 0);
    chk("flush_address", o_address, 24);

    cyc(0, 0, 1, 32'h42);
    chk("misalign_address", o_address, 32'h42);
    chk("misalign_pre_halt", 32'(o_halted), 0);
    cyc(0, 0, 0, 0);
    chk("misalign_halted", 32'(o_halted), 1);
    chk("misalign_valid", 32'(o_valid), 0);
    cyc(0, 0, 1, 32'h10);
    chk("halt_ignores_redirect", o_address, 32'h42);
    async_reset();
    cyc(0, 0, 0, 0);
    chk("restart_address", o_address, 4);
    chk("restart_valid", 32'(o_valid), 1);

    cyc(0, 0, 1, 32'h80);
    cyc(0, 0, 0, 0);
    chk("range_halted", 32'(o_halted), 1);
    chk("range_valid", 32'(o_valid), 0);
    cyc(0, 0, 1, 0);
    chk("range_frozen", o_address, 32'h80);

    async_reset();
    for (int n = 0; n < 800; n++) begin
      if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) async_reset();
      else begin
        r = $urandom_range(0, 39);
        tgt = r == 0 ? $urandom : r == 1 ? 32'(4 * $urandom_range(32, 40)) : 32'(4 * $urandom_range(0, 31));
        cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, tgt);
      end
    end
    run_cmp = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
